pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/forwarding control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if;
   logic [4:0]  rs1D;
   logic [4:0]  rs2D;
   logic [4:0]  rs1E;
   logic [4:0]  rs2E;
   logic [4:0]  rdE;
   logic        memReadE;
   logic        pcsrcE;
   logic [4:0]  rdM;
   logic        regwriteM;
   logic [4:0]  rdW;
   logic        regwriteW;
   logic        memBusyM;
   logic        stallF;
   logic        stallD;
   logic        stallE;
   logic        stallM;
   logic        flushD;
   logic        flushE;
   logic [1:0]  forwardAE;
   logic [1:0]  forwardBE;
   logic        memTimeout;
   logic [31:0] stallCount;
   logic [31:0] flushCount;

   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, memReadE, pcsrcE,
             rdM, regwriteM, rdW, regwriteW, memBusyM,
      input  stallF, stallD, stallE, stallM, flushD, flushE,
             forwardAE, forwardBE, memTimeout, stallCount, flushCount
   );

   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, memReadE, pcsrcE,
             rdM, regwriteM, rdW, regwriteW, memBusyM,
      output stallF, stallD, stallE, stallM, flushD, flushE,
             forwardAE, forwardBE, memTimeout, stallCount, flushCount
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard unit: stalls, flushes, operand forwarding and a memory-wait watchdog.
// Defining PIPELINE_CTRL_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_ctrl #(
   parameter int WAIT_TIMEOUT = 15
) (
   input logic            CLK,
   input logic            RST,
   pipeline_ctrl_if.slave bus
);
   localparam int              CW      = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CW-1:0]   WT_C    = CW'(WAIT_TIMEOUT);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [0:0]      RUN     = 1'b0;
   localparam logic [0:0]      MEMWAIT = 1'b1;

   logic [0:0]    state_r;
   logic [0:0]    state_nxt_s;
   logic [CW-1:0] wait_cnt_r;
   logic [CW-1:0] wait_cnt_nxt_s;
   logic          mem_timeout_r;
   logic          timeout_hit_s;
   logic          load_use_s;
   logic          stall_f_s, stall_d_s, stall_e_s, stall_m_s;
   logic          flush_d_s, flush_e_s;
   logic [1:0]    fwd_a_s, fwd_b_s;

   // The M-stage producer is younger than W, so it wins; x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic wr_m, input logic [4:0] rd_m,
                                          input logic wr_w, input logic [4:0] rd_w);
      logic [1:0] sel;
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign load_use_s = bus.memReadE && (bus.rdE != 5'd0) &&
                       ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));

   // Prioritised stall/flush/forward decode; pcsrcE beats load-use since Decode is on the wrong path.
   always_comb begin
      stall_f_s = 1'b0;
      stall_d_s = 1'b0;
      stall_e_s = 1'b0;
      stall_m_s = 1'b0;
      flush_d_s = 1'b0;
      flush_e_s = 1'b0;
      fwd_a_s   = 2'b00;
      fwd_b_s   = 2'b00;
      if (RST) begin
         flush_d_s = 1'b1;
         flush_e_s = 1'b1;
      end else begin
         fwd_a_s = fwd_sel(bus.rs1E, bus.regwriteM, bus.rdM, bus.regwriteW, bus.rdW);
         fwd_b_s = fwd_sel(bus.rs2E, bus.regwriteM, bus.rdM, bus.regwriteW, bus.rdW);
         if (bus.memBusyM) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
         end else if (bus.pcsrcE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
         end else if (load_use_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
         end else begin
            flush_d_s = 1'b0;
         end
      end
   end

   // Memory-wait FSM next state; waitCnt counts busy cycles spent in MEMWAIT and saturates.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      case (state_r)
         RUN: begin
            wait_cnt_nxt_s = {CW{1'b0}};
            if (bus.memBusyM) begin
               state_nxt_s = MEMWAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         MEMWAIT: begin
            if (bus.memBusyM) begin
               state_nxt_s = MEMWAIT;
               if (wait_cnt_r < WT_C) begin
                  wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r;
               end
            end else begin
               state_nxt_s    = RUN;
               wait_cnt_nxt_s = {CW{1'b0}};
            end
         end
         default: begin
            state_nxt_s    = RUN;
            wait_cnt_nxt_s = {CW{1'b0}};
         end
      endcase
   end

   assign timeout_hit_s = (state_r == MEMWAIT) && bus.memBusyM && (wait_cnt_nxt_s == WT_C);

   // FSM, wait counter and sticky timeout flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r       <= RUN;
         wait_cnt_r    <= {CW{1'b0}};
         mem_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         mem_timeout_r <= mem_timeout_r | timeout_hit_s;
      end
   end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating performance counters, sampled from the decoded stall/flush of each cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (stall_f_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (flush_e_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end
      end
   end

   assign bus.stallCount = stall_cnt_r;
   assign bus.flushCount = flush_cnt_r;
`else
   assign bus.stallCount = 32'd0;
   assign bus.flushCount = 32'd0;
`endif

   assign bus.stallF     = stall_f_s;
   assign bus.stallD     = stall_d_s;
   assign bus.stallE     = stall_e_s;
   assign bus.stallM     = stall_m_s;
   assign bus.flushD     = flush_d_s;
   assign bus.flushE     = flush_e_s;
   assign bus.forwardAE  = fwd_a_s;
   assign bus.forwardBE  = fwd_b_s;
   assign bus.memTimeout = mem_timeout_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_pipeline_ctrl;
   localparam int WT = 15;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
   localparam logic [31:0] EXP_STALL_045 = 32'd4;
   localparam logic [31:0] EXP_FLUSH_045 = 32'd2;
`else
   localparam logic [31:0] EXP_STALL_045 = 32'd0;
   localparam logic [31:0] EXP_FLUSH_045 = 32'd0;
`endif

   logic CLK;
   logic RST;
   int   vectors;
   int   miscompares;

   // Model state: consecutive busy edges, sticky timeout, event tallies.
   int          m_consec;
   logic        m_timeout;
   logic [31:0] m_stall;
   logic [31:0] m_flush;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.WAIT_TIMEOUT(WT)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (bus.regwriteM && bus.rdM == rs) return 2'b10;
      if (bus.regwriteW && bus.rdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle();
      bus.rs1D = 5'd0; bus.rs2D = 5'd0; bus.rs1E = 5'd0; bus.rs2E = 5'd0;
      bus.rdE = 5'd0; bus.rdM = 5'd0; bus.rdW = 5'd0;
      bus.memReadE = 1'b0; bus.pcsrcE = 1'b0; bus.regwriteM = 1'b0;
      bus.regwriteW = 1'b0; bus.memBusyM = 1'b0;
   endtask

   // Check the combinational outputs, clock once, advance the model, check registered outputs.
   task automatic tick(input string tag);
      logic sf, sd, se, sm, fd, fe, lu;
      logic [1:0] fa, fb;
      #1;
      {sf, sd, se, sm, fd, fe} = 6'b000000;
      fa = 2'b00;
      fb = 2'b00;
      lu = bus.memReadE && (bus.rdE != 5'd0) && (bus.rdE == bus.rs1D || bus.rdE == bus.rs2D);
      if (RST) begin
         fd = 1'b1; fe = 1'b1;
      end else begin
         fa = ref_fwd(bus.rs1E);
         fb = ref_fwd(bus.rs2E);
         if (bus.memBusyM)    {sf, sd, se, sm} = 4'b1111;
         else if (bus.pcsrcE) {fd, fe} = 2'b11;
         else if (lu)         {sf, sd, fe} = 3'b111;
      end
      check({tag, "/stallF"}, 32'(bus.stallF), 32'(sf));
      check({tag, "/stallD"}, 32'(bus.stallD), 32'(sd));
      check({tag, "/stallE"}, 32'(bus.stallE), 32'(se));
      check({tag, "/stallM"}, 32'(bus.stallM), 32'(sm));
      check({tag, "/flushD"}, 32'(bus.flushD), 32'(fd));
      check({tag, "/flushE"}, 32'(bus.flushE), 32'(fe));
      check({tag, "/fwdA"}, 32'(bus.forwardAE), 32'(fa));
      check({tag, "/fwdB"}, 32'(bus.forwardBE), 32'(fb));
      @(posedge CLK);
      if (RST) begin
         m_consec = 0; m_timeout = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
      end else begin
         m_consec = bus.memBusyM ? m_consec + 1 : 0;
         // First busy edge only enters the wait; the next WT busy edges exhaust it.
         if (m_consec >= WT + 1) m_timeout = 1'b1;
         if (sf && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         if (fe && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
      end
      #1;
      check({tag, "/memTimeout"}, 32'(bus.memTimeout), 32'(m_timeout));
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      check({tag, "/stallCount"}, bus.stallCount, m_stall);
      check({tag, "/flushCount"}, bus.flushCount, m_flush);
`else
      check({tag, "/stallCount"}, bus.stallCount, 32'd0);
      check({tag, "/flushCount"}, bus.flushCount, 32'd0);
`endif
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      m_consec = 0; m_timeout = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
      RST = 1'b1;
      idle();
      tick("reset0");
      tick("reset1");
      RST = 1'b0;
      tick("idle");

      // Load-use: hit on rs1D, hit on rs2D, then x0 destination.
      bus.memReadE = 1'b1; bus.rdE = 5'd5; bus.rs1D = 5'd5;
      tick("lu_rs1");
      idle();
      tick("lu_gone");
      bus.memReadE = 1'b1; bus.rdE = 5'd7; bus.rs2D = 5'd7;
      tick("lu_rs2");
      idle();
      bus.memReadE = 1'b1; bus.rdE = 5'd0; bus.rs1D = 5'd0;
      tick("lu_x0");
      idle();
      bus.memReadE = 1'b1; bus.rdE = 5'd5; bus.rs1D = 5'd5; bus.pcsrcE = 1'b1;
      tick("lu_branch");
      idle();

      // Forwarding priority and x0.
      bus.regwriteM = 1'b1; bus.rdM = 5'd3; bus.regwriteW = 1'b1; bus.rdW = 5'd3;
      bus.rs1E = 5'd3; bus.rs2E = 5'd3;
      tick("fwd_m");
      bus.regwriteM = 1'b0;
      tick("fwd_w");
      bus.rs1E = 5'd0;
      tick("fwd_x0");
      bus.regwriteM = 1'b1; bus.rdM = 5'd0; bus.rs2E = 5'd0;
      tick("fwd_rd0");
      idle();

      // Branch held across a 3-cycle memory wait must flush on release.
      bus.memBusyM = 1'b1; bus.pcsrcE = 1'b1;
      repeat (3) tick("busy_br");
      bus.memBusyM = 1'b0;
      tick("br_release");
      bus.pcsrcE = 1'b0;
      tick("br_done");

      // Watchdog: 20 busy cycles, sticky until reset.
      bus.memBusyM = 1'b1;
      repeat (20) tick("busy20");
      check("timeout_after20", 32'(bus.memTimeout), 32'd1);
      bus.memBusyM = 1'b0;
      repeat (3) tick("sticky");
      RST = 1'b1;
      tick("rst_clear");
      RST = 1'b0;
      bus.memBusyM = 1'b1;
      repeat (5) tick("busy5");
      RST = 1'b1;
      tick("rst_midwait");
      RST = 1'b0;
      repeat (16) tick("busy_after_rst");
      bus.memBusyM = 1'b0;
      tick("release");

      // Counters: 4 stalls then 2 flushes from a clean reset.
      RST = 1'b1;
      idle();
      tick("cnt_rst");
      RST = 1'b0;
      bus.memBusyM = 1'b1;
      repeat (4) tick("cnt_stall");
      bus.memBusyM = 1'b0; bus.pcsrcE = 1'b1;
      repeat (2) tick("cnt_flush");
      idle();
      tick("cnt_idle");
      check("stallCount_045", bus.stallCount, EXP_STALL_045);
      check("flushCount_045", bus.flushCount, EXP_FLUSH_045);

      // Random traffic with a small register set to provoke matches.
      for (int i = 0; i < 400; i++) begin
         RST           = ($urandom_range(0, 49) == 0);
         bus.rs1D      = 5'($urandom_range(0, 3));
         bus.rs2D      = 5'($urandom_range(0, 3));
         bus.rs1E      = 5'($urandom_range(0, 3));
         bus.rs2E      = 5'($urandom_range(0, 3));
         bus.rdE       = 5'($urandom_range(0, 3));
         bus.rdM       = 5'($urandom_range(0, 3));
         bus.rdW       = 5'($urandom_range(0, 3));
         bus.memReadE  = ($urandom_range(0, 2) == 0);
         bus.pcsrcE    = ($urandom_range(0, 5) == 0);
         bus.regwriteM = 1'($urandom_range(0, 1));
         bus.regwriteW = 1'($urandom_range(0, 1));
         bus.memBusyM  = ($urandom_range(0, 4) == 0);
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
